// File: rtl/timer_host_master.sv
// -----------------------------------------------------------------------------
// timer_host_master
//
// Avalon-MM master that programs an interval-timer slave, services its
// timeout interrupt and (optionally) reads back the slave's counter snapshot
// after every serviced timeout.
//
// Slave word map: 0 status, 1 control, 2 period_l, 3 period_h,
//                 4 snap_l, 5 snap_h.
//
// Parameters
//   SNAP_EN    1 = read the counter snapshot after each timeout, 0 = skip it
//   TICK_W     width of tick_count
//
// Ports
//   clk          single clock for all logic
//   reset_n      asynchronous active-low reset
//   cfg_start    one-cycle pulse: program period and start the timer (IDLE only)
//   cfg_stop     one-cycle pulse: stop the timer (ignored in IDLE)
//   cfg_period   32-bit period, sampled when cfg_start is accepted
//   m_address    master word address
//   m_chipselect access strobe (single-cycle accesses, no waitrequest)
//   m_write_n    active-low write
//   m_writedata  write data
//   m_readdata   read data, registered by the slave (valid cycle after address)
//   irq          level-sensitive timer interrupt, active high
//   busy         high whenever the engine is not IDLE
//   tick         one-cycle pulse per serviced timeout
//   tick_count   serviced timeouts since the last start (wraps)
//   snapshot     last counter snapshot, {snap_h, snap_l}
//
// All outputs are registered: the next-state values are computed in one
// always_comb block and loaded by a single always_ff, so every bus strobe is
// aligned with the state that issues it.
// -----------------------------------------------------------------------------
module timer_host_master #(
  parameter int SNAP_EN = 1,
  parameter int TICK_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot
);

  // Slave register addresses
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PER_L  = 3'd2;
  localparam logic [2:0] ADDR_PER_H  = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H = 3'd5;

  // Control words: ITO | CONT | START, and STOP with ITO cleared
  localparam logic [15:0] CTRL_RUN  = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_PL    = 4'd1,
    WR_PH    = 4'd2,
    WR_CTRL  = 4'd3,
    WAIT_IRQ = 4'd4,
    CLR_ST   = 4'd5,
    SNAP_WR  = 4'd6,
    RD_SL    = 4'd7,
    RD_SH    = 4'd8,
    RD_DONE  = 4'd9,
    WR_STOP  = 4'd10
  } state_e;

  state_e              state_q,        state_d;
  logic [31:0]         period_q,       period_d;
  logic [TICK_W-1:0]   tick_count_q,   tick_count_d;
  logic [31:0]         snapshot_q,     snapshot_d;
  logic [15:0]         snap_lo_q,      snap_lo_d;
  logic                stop_pending_q, stop_pending_d;
  logic                wait_armed_q,   wait_armed_d;
  logic [2:0]          m_address_q,    m_address_d;
  logic                m_chipselect_q, m_chipselect_d;
  logic                m_write_n_q,    m_write_n_d;
  logic [15:0]         m_writedata_q,  m_writedata_d;
  logic                busy_q,         busy_d;
  logic                tick_q,         tick_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    tick_count_d   = tick_count_q;
    snapshot_d     = snapshot_q;
    snap_lo_d      = snap_lo_q;
    stop_pending_d = stop_pending_q;
    // Armed only after a full cycle spent in WAIT_IRQ; cleared everywhere else.
    wait_armed_d   = 1'b0;

    // A stop request is remembered in any active state and honoured only in
    // WAIT_IRQ, so programming and service sequences always run to completion.
    if (state_q != IDLE && cfg_stop) begin
      stop_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Start wins over a coincident stop; stop alone is ignored here.
        if (cfg_start) begin
          period_d     = cfg_period;
          tick_count_d = '0;
          state_d      = WR_PL;
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        wait_armed_d = 1'b1;
        if (stop_pending_q || cfg_stop) begin
          state_d = WR_STOP;
        end else if (wait_armed_q && irq) begin
          // The slave drops irq a cycle after the status clear, so irq can
          // still be high on the first cycle back here; wait_armed_q masks it.
          state_d      = CLR_ST;
          tick_count_d = tick_count_q + TICK_W'(1);
        end
      end
      CLR_ST: begin
        if (SNAP_EN != 0) begin
          state_d = SNAP_WR;
        end else begin
          state_d = WAIT_IRQ;
        end
      end
      SNAP_WR: state_d = RD_SL;
      RD_SL:   state_d = RD_SH;
      RD_SH: begin
        // Data for the snap_l read issued in RD_SL is on the bus now.
        snap_lo_d = m_readdata;
        state_d   = RD_DONE;
      end
      RD_DONE: begin
        // Both halves are published together so snapshot is never torn.
        snapshot_d = {m_readdata, snap_lo_q};
        state_d    = WAIT_IRQ;
      end
      WR_STOP: begin
        stop_pending_d = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the state being entered so that
    // each strobe is presented during the cycle its state is resident.
    m_chipselect_d = 1'b0;
    m_write_n_d    = 1'b1;
    m_address_d    = 3'd0;
    m_writedata_d  = 16'h0000;
    tick_d         = 1'b0;
    busy_d         = (state_d != IDLE);

    case (state_d)
      WR_PL: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_PER_L;
        m_writedata_d  = period_d[15:0];
      end
      WR_PH: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_PER_H;
        m_writedata_d  = period_d[31:16];
      end
      WR_CTRL: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CTRL;
        m_writedata_d  = CTRL_RUN;
      end
      CLR_ST: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_STATUS;
        m_writedata_d  = 16'h0000;
        tick_d         = 1'b1;
      end
      SNAP_WR: begin
        // Any write to snap_l makes the slave latch its live counter.
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_SNAP_L;
        m_writedata_d  = 16'h0000;
      end
      RD_SL: begin
        m_chipselect_d = 1'b1;
        m_address_d    = ADDR_SNAP_L;
      end
      RD_SH: begin
        m_chipselect_d = 1'b1;
        m_address_d    = ADDR_SNAP_H;
      end
      WR_STOP: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CTRL;
        m_writedata_d  = CTRL_STOP;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      period_q       <= 32'h0;
      tick_count_q   <= '0;
      snapshot_q     <= 32'h0;
      snap_lo_q      <= 16'h0;
      stop_pending_q <= 1'b0;
      wait_armed_q   <= 1'b0;
      m_address_q    <= 3'd0;
      m_chipselect_q <= 1'b0;
      m_write_n_q    <= 1'b1;
      m_writedata_q  <= 16'h0;
      busy_q         <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      tick_count_q   <= tick_count_d;
      snapshot_q     <= snapshot_d;
      snap_lo_q      <= snap_lo_d;
      stop_pending_q <= stop_pending_d;
      wait_armed_q   <= wait_armed_d;
      m_address_q    <= m_address_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_n_q    <= m_write_n_d;
      m_writedata_q  <= m_writedata_d;
      busy_q         <= busy_d;
      tick_q         <= tick_d;
    end
  end

  assign m_address    = m_address_q;
  assign m_chipselect = m_chipselect_q;
  assign m_write_n    = m_write_n_q;
  assign m_writedata  = m_writedata_q;
  assign busy         = busy_q;
  assign tick         = tick_q;
  assign tick_count   = tick_count_q;
  assign snapshot     = snapshot_q;

endmodule

// File: doc/timer_host_master.md
TIMER_HOST_MASTER -- requirements
Module: timer_host_master

Interface
REQ-001 SHALL have parameter SNAP_EN, default 1, meaning 1 = read back the counter snapshot after every timeout and 0 = skip snapshot.
REQ-002 SHALL have parameter TICK_W, default 32, meaning width of tick_count.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_start  input  1  one-cycle pulse requesting programming and start of the timer.
REQ-006 SHALL have port cfg_stop  input  1  one-cycle pulse requesting the timer be stopped.
REQ-007 SHALL have port cfg_period  input  32  period value, sampled on accepted cfg_start.
REQ-008 SHALL have port m_address  output  3  Avalon-MM master word address.
REQ-009 SHALL have port m_chipselect  output  1  Avalon-MM access strobe.
REQ-010 SHALL have port m_write_n  output  1  Avalon-MM active-low write.
REQ-011 SHALL have port m_writedata  output  16  Avalon-MM write data.
REQ-012 SHALL have port m_readdata  input  16  Avalon-MM read data, registered by the slave and valid the cycle after the address.
REQ-013 SHALL have port irq  input  1  timer interrupt, level, active high.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port tick  output  1  one-cycle pulse per serviced timeout.
REQ-016 SHALL have port tick_count  output  TICK_W  count of serviced timeouts since the last start.
REQ-017 SHALL have port snapshot  output  32  last counter snapshot read back as {high, low}.

Function
REQ-018 SHALL use slave map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-019 SHALL perform a write as exactly one cycle with m_chipselect=1, m_write_n=0; no waitrequest exists.
REQ-020 SHALL perform a read as one cycle with m_chipselect=1, m_write_n=1, then capture m_readdata on the following clock edge.
REQ-021 SHALL drive m_chipselect=0, m_write_n=1, m_address=0 and m_writedata=0 when not accessing.
REQ-022 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, SNAP_WR, RD_SL, RD_SH, RD_DONE and WR_STOP.
REQ-023 SHALL, in IDLE on cfg_start, latch cfg_period, clear tick_count to 0 and go to WR_PL.
REQ-024 SHALL write cfg_period[15:0] to address 2 in WR_PL, cfg_period[31:16] to address 3 in WR_PH, and 16'h0007 (ITO, CONT, START) to address 1 in WR_CTRL, one state per cycle, then go to WAIT_IRQ.
REQ-025 SHALL, in WAIT_IRQ with irq=1, go to CLR_ST.
REQ-026 SHALL write 16'h0000 to address 0 in CLR_ST, pulse tick, and increment tick_count modulo 2^TICK_W, wrapping from all-ones to 0.
REQ-027 SHALL go from CLR_ST to SNAP_WR when SNAP_EN=1, or to WAIT_IRQ when SNAP_EN=0.
REQ-028 SHALL write 16'h0000 to address 4 in SNAP_WR, read address 4 in RD_SL, read address 5 in RD_SH while capturing low data, and capture high data in RD_DONE.
REQ-029 SHALL update snapshot atomically in RD_DONE, then go to WAIT_IRQ.
REQ-030 SHALL set a stop_pending flag on cfg_stop in any non-IDLE state.
REQ-031 SHALL, in WAIT_IRQ with stop_pending set or cfg_stop asserted, go to WR_STOP with priority over irq; pending stops are acted on only in WAIT_IRQ, so programming and service sequences are never truncated.
REQ-032 SHALL write 16'h0008 (STOP, ITO=0) to address 1 in WR_STOP, clear stop_pending and go to IDLE.
REQ-033 SHALL ignore cfg_start when not in IDLE, and ignore cfg_stop in IDLE.
REQ-034 SHALL give start priority when cfg_start and cfg_stop coincide in IDLE.
REQ-035 SHALL not count an irq that is still high when WAIT_IRQ is re-entered after CLR_ST (slave clears the cause one cycle later) more than once; WAIT_IRQ SHALL require one cycle of residency before sampling irq.

Reset
REQ-036 SHALL, on reset_n=0 at any time including mid-sequence, asynchronously force state IDLE, bus outputs per REQ-021, busy=0, tick=0, tick_count=0, snapshot=0, stop_pending=0 and latched period=0.
REQ-037 SHALL resume with the first clock edge after reset_n deasserts, issuing no bus access until cfg_start.

Verification
REQ-038 SHALL verify: cfg_start, cfg_period=32'h0001_86A0 -> writes (2,86A0),(3,0001),(1,0007) on 3 consecutive cycles; busy=1.
REQ-039 SHALL verify: irq held high 3 cycles, slave model snapshot 32'h0000_1234 -> write (0,0000), tick pulse, tick_count=1, reads 4 then 5, snapshot=32'h0000_1234.
REQ-040 SHALL verify: cfg_stop during WR_PH -> WR_CTRL still issued, then write (1,0008), busy=0 two cycles after WAIT_IRQ entry.
REQ-041 SHALL verify: cfg_stop and irq both high in WAIT_IRQ -> write (1,0008), no status clear, tick_count unchanged.
REQ-042 SHALL verify: TICK_W=4, 17 timeouts -> tick_count=1 after wrap.
REQ-043 SHALL verify: reset_n low during RD_SH -> all outputs 0/idle immediately, snapshot=0, and a new cfg_start restarts at WR_PL.
